// File: rtl/cursor_uart_rx.sv
// Receives the 6-byte cursor packet stream: 8N1 UART deserialiser feeding a sync/version/CRC8 checking parser.
// Optional frame_id continuity checking is built when CURSOR_RX_SEQ_CHECK_EN is defined.
module cursor_uart_rx #(
   parameter int unsigned CLKS_PER_BIT = 217,
   parameter int unsigned TIMEOUT_BITS = 20,
   parameter logic [1:0]  VERSION      = 2'b01
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       valid,
   output logic [1:0] buttons,
   output logic [3:0] safety_flags,
   output logic [7:0] dx,
   output logic [7:0] dy,
   output logic [7:0] frame_id,
   output logic       crc_err,
   output logic       hdr_err,
   output logic       frame_err,
   output logic       timeout_err,
   output logic [7:0] err_count,
   output logic       seq_gap,
   output logic [7:0] drop_count
);

   localparam int unsigned CNT_W    = $clog2(CLKS_PER_BIT);
   localparam int unsigned TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
   localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
   localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [TO_W-1:0]  TO_M1   = TO_W'(TO_LIMIT - 1);

   typedef enum logic [1:0] {BS_IDLE, BS_START, BS_DATA, BS_STOP} bstate_e;
   typedef enum logic [2:0] {P_HUNT, P_B1, P_B2, P_B3, P_B4, P_B5} pstate_e;

   function automatic logic [7:0] crc8_upd(input logic [7:0] c, input logic [7:0] b);
      logic [7:0] r;
      r = c ^ b;
      for (int i = 0; i < 8; i++) begin
         r = r[7] ? ((r << 1) ^ 8'h07) : (r << 1);
      end
      return r;
   endfunction

   // rx_prev_q is a third stage used only for falling-edge detection
   logic rx_meta_q, rx_s_q, rx_prev_q;
   logic fall_edge;

   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         rx_prev_q <= 1'b1;
      end else begin
         rx_meta_q <= rx;
         rx_s_q    <= rx_meta_q;
         rx_prev_q <= rx_s_q;
      end
   end

   assign fall_edge = rx_prev_q & ~rx_s_q;

   bstate_e          bst_q, bst_d;
   logic [CNT_W-1:0] bcnt_q, bcnt_d;
   logic [2:0]       bidx_q, bidx_d;
   logic [7:0]       shift_q, shift_d;
   logic             byte_done, stop_bad;

   always_comb begin
      bst_d     = bst_q;
      bcnt_d    = bcnt_q;
      bidx_d    = bidx_q;
      shift_d   = shift_q;
      byte_done = 1'b0;
      stop_bad  = 1'b0;
      case (bst_q)
         BS_IDLE: begin
            if (fall_edge) begin
               bst_d  = BS_START;
               bcnt_d = '0;
            end
         end
         BS_START: begin
            if (bcnt_q == HALF_M1) begin
               bcnt_d = '0;
               bidx_d = 3'd0;
               bst_d  = rx_s_q ? BS_IDLE : BS_DATA;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         BS_DATA: begin
            if (bcnt_q == FULL_M1) begin
               bcnt_d  = '0;
               shift_d = {rx_s_q, shift_q[7:1]};
               if (bidx_q == 3'd7) bst_d = BS_STOP;
               else                bidx_d = bidx_q + 3'd1;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         BS_STOP: begin
            // back to IDLE at mid-stop so the next start edge is not missed
            if (bcnt_q == FULL_M1) begin
               bcnt_d = '0;
               bst_d  = BS_IDLE;
               if (rx_s_q) byte_done = 1'b1;
               else        stop_bad  = 1'b1;
            end else begin
               bcnt_d = bcnt_q + 1'b1;
            end
         end
         default: bst_d = BS_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bst_q   <= BS_IDLE;
         bcnt_q  <= '0;
         bidx_q  <= 3'd0;
         shift_q <= 8'h00;
      end else begin
         bst_q   <= bst_d;
         bcnt_q  <= bcnt_d;
         bidx_q  <= bidx_d;
         shift_q <= shift_d;
      end
   end

   pstate_e         pst_q, pst_d;
   logic [7:0]      sh_b1_q, sh_b1_d, sh_dx_q, sh_dx_d, sh_dy_q, sh_dy_d, sh_fid_q, sh_fid_d;
   logic [7:0]      crc_q, crc_d, crc_fin;
   logic [TO_W-1:0] idle_q, idle_d;
   logic            timeout_hit, accept, err_any;
   logic            valid_q, valid_d, crc_err_q, crc_err_d, hdr_err_q, hdr_err_d;
   logic            frame_err_q, frame_err_d, timeout_err_q, timeout_err_d;
   logic [1:0]      btn_q, btn_d;
   logic [3:0]      saf_q, saf_d;
   logic [7:0]      dx_q, dx_d, dy_q, dy_d, fid_q, fid_d, err_cnt_q, err_cnt_d;

   assign timeout_hit = (pst_q != P_HUNT) && (bst_q == BS_IDLE) && !fall_edge && (idle_q == TO_M1);
   assign crc_fin     = crc8_upd(crc_q, 8'h00);

   always_comb begin
      if (pst_q == P_HUNT || bst_q != BS_IDLE || fall_edge) idle_d = '0;
      else                                                  idle_d = idle_q + 1'b1;
   end

   always_comb begin
      pst_d         = pst_q;
      sh_b1_d       = sh_b1_q;
      sh_dx_d       = sh_dx_q;
      sh_dy_d       = sh_dy_q;
      sh_fid_d      = sh_fid_q;
      crc_d         = crc_q;
      accept        = 1'b0;
      valid_d       = 1'b0;
      crc_err_d     = 1'b0;
      hdr_err_d     = 1'b0;
      frame_err_d   = 1'b0;
      timeout_err_d = 1'b0;
      btn_d         = btn_q;
      saf_d         = saf_q;
      dx_d          = dx_q;
      dy_d          = dy_q;
      fid_d         = fid_q;
      err_cnt_d     = err_cnt_q;

      if (stop_bad) begin
         frame_err_d = 1'b1;
         pst_d       = P_HUNT;
      end else if (byte_done) begin
         case (pst_q)
            P_HUNT: if (shift_q == 8'hAA) pst_d = P_B1;
            P_B1: begin
               sh_b1_d = shift_q;
               crc_d   = crc8_upd(8'h00, shift_q);
               pst_d   = P_B2;
            end
            P_B2: begin
               sh_dx_d = shift_q;
               crc_d   = crc8_upd(crc_q, shift_q);
               pst_d   = P_B3;
            end
            P_B3: begin
               sh_dy_d = shift_q;
               crc_d   = crc8_upd(crc_q, shift_q);
               pst_d   = P_B4;
            end
            P_B4: begin
               sh_fid_d = shift_q;
               crc_d    = crc8_upd(crc_q, shift_q);
               pst_d    = P_B5;
            end
            P_B5: begin
               pst_d = P_HUNT;
               if (sh_b1_q[7:6] != VERSION) hdr_err_d = 1'b1;
               else if (shift_q != crc_fin) crc_err_d = 1'b1;
               else                         accept    = 1'b1;
            end
            default: pst_d = P_HUNT;
         endcase
      end else if (timeout_hit) begin
         timeout_err_d = 1'b1;
         pst_d         = P_HUNT;
      end

      if (accept) begin
         valid_d = 1'b1;
         btn_d   = sh_b1_q[5:4];
         saf_d   = sh_b1_q[3:0];
         dx_d    = sh_dx_q;
         dy_d    = sh_dy_q;
         fid_d   = sh_fid_q;
      end

      err_any = frame_err_d | hdr_err_d | crc_err_d | timeout_err_d;
      if (err_any && err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pst_q         <= P_HUNT;
         sh_b1_q       <= 8'h00;
         sh_dx_q       <= 8'h00;
         sh_dy_q       <= 8'h00;
         sh_fid_q      <= 8'h00;
         crc_q         <= 8'h00;
         idle_q        <= '0;
         valid_q       <= 1'b0;
         crc_err_q     <= 1'b0;
         hdr_err_q     <= 1'b0;
         frame_err_q   <= 1'b0;
         timeout_err_q <= 1'b0;
         btn_q         <= 2'b00;
         saf_q         <= 4'h0;
         dx_q          <= 8'h00;
         dy_q          <= 8'h00;
         fid_q         <= 8'h00;
         err_cnt_q     <= 8'h00;
      end else begin
         pst_q         <= pst_d;
         sh_b1_q       <= sh_b1_d;
         sh_dx_q       <= sh_dx_d;
         sh_dy_q       <= sh_dy_d;
         sh_fid_q      <= sh_fid_d;
         crc_q         <= crc_d;
         idle_q        <= idle_d;
         valid_q       <= valid_d;
         crc_err_q     <= crc_err_d;
         hdr_err_q     <= hdr_err_d;
         frame_err_q   <= frame_err_d;
         timeout_err_q <= timeout_err_d;
         btn_q         <= btn_d;
         saf_q         <= saf_d;
         dx_q          <= dx_d;
         dy_q          <= dy_d;
         fid_q         <= fid_d;
         err_cnt_q     <= err_cnt_d;
      end
   end

   assign valid        = valid_q;
   assign buttons      = btn_q;
   assign safety_flags = saf_q;
   assign dx           = dx_q;
   assign dy           = dy_q;
   assign frame_id     = fid_q;
   assign crc_err      = crc_err_q;
   assign hdr_err      = hdr_err_q;
   assign frame_err    = frame_err_q;
   assign timeout_err  = timeout_err_q;
   assign err_count    = err_cnt_q;

`ifdef CURSOR_RX_SEQ_CHECK_EN
   logic [7:0] prev_fid_q, gap, drop_q;
   logic [8:0] drop_sum;
   logic       have_prev_q, seq_gap_q;

   // a repeated frame_id wraps to a gap of 255
   always_comb begin
      gap      = sh_fid_q - prev_fid_q - 8'd1;
      drop_sum = {1'b0, drop_q} + {1'b0, gap};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         prev_fid_q  <= 8'h00;
         have_prev_q <= 1'b0;
         seq_gap_q   <= 1'b0;
         drop_q      <= 8'h00;
      end else begin
         seq_gap_q <= 1'b0;
         if (accept) begin
            prev_fid_q  <= sh_fid_q;
            have_prev_q <= 1'b1;
            if (have_prev_q) begin
               seq_gap_q <= (gap != 8'h00);
               drop_q    <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
            end
         end
      end
   end

   assign seq_gap    = seq_gap_q;
   assign drop_count = drop_q;
`else
   assign seq_gap    = 1'b0;
   assign drop_count = 8'h00;
`endif

endmodule

// File: tb/tb_cursor_uart_rx.sv
// Directed bench for cursor_uart_rx: table of packets with expected strobes/fields, plus hand sequences
// for timeout, start-bit glitch, reset mid-byte, error-count saturation and (with the macro) sequence gaps.
module tb_cursor_uart_rx;
   localparam int CPB = 8;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       valid, crc_err, hdr_err, frame_err, timeout_err, seq_gap;
   logic [1:0] buttons;
   logic [3:0] safety_flags;
   logic [7:0] dx, dy, frame_id, err_count, drop_count;

   cursor_uart_rx #(.CLKS_PER_BIT(CPB), .TIMEOUT_BITS(20), .VERSION(2'b01)) dut (
      .clk(clk), .rst(rst), .rx(rx), .valid(valid), .buttons(buttons),
      .safety_flags(safety_flags), .dx(dx), .dy(dy), .frame_id(frame_id),
      .crc_err(crc_err), .hdr_err(hdr_err), .frame_err(frame_err),
      .timeout_err(timeout_err), .err_count(err_count), .seq_gap(seq_gap),
      .drop_count(drop_count)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int c_val = 0, c_crc = 0, c_hdr = 0, c_frm = 0, c_to = 0, c_seq = 0;
   int s_val, s_crc, s_hdr, s_frm, s_to, s_seq;

   always @(negedge clk) begin
      if (valid)       c_val <= c_val + 1;
      if (crc_err)     c_crc <= c_crc + 1;
      if (hdr_err)     c_hdr <= c_hdr + 1;
      if (frame_err)   c_frm <= c_frm + 1;
      if (timeout_err) c_to  <= c_to + 1;
      if (seq_gap)     c_seq <= c_seq + 1;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   task automatic snap();
      s_val = c_val; s_crc = c_crc; s_hdr = c_hdr; s_frm = c_frm; s_to = c_to; s_seq = c_seq;
   endtask

   // CRC as polynomial long division of {b1..b4, 00} * x^8
   function automatic logic [7:0] crc_ref(input logic [7:0] b1, b2, b3, b4);
      logic [47:0] v;
      v = {b1, b2, b3, b4, 16'h0000};
      for (int i = 47; i >= 8; i--) begin
         if (v[i]) v[i -: 9] = v[i -: 9] ^ 9'h107;
      end
      return v[7:0];
   endfunction

   task automatic send_bit(input logic b);
      rx = b;
      repeat (CPB) @(negedge clk);
   endtask

   task automatic idle_bits(input int n);
      for (int i = 0; i < n; i++) send_bit(1'b1);
   endtask

   task automatic send_byte(input logic [7:0] b, input logic stop);
      send_bit(1'b0);
      for (int i = 0; i < 8; i++) send_bit(b[i]);
      send_bit(stop);
   endtask

   task automatic send_pkt(input logic [7:0] b1, b2, b3, b4, input logic [7:0] crc_xor, input int bad_stop);
      logic [7:0] pk [6];
      pk[0] = 8'hAA; pk[1] = b1; pk[2] = b2; pk[3] = b3; pk[4] = b4;
      pk[5] = crc_ref(b1, b2, b3, b4) ^ crc_xor;
      for (int i = 0; i < 6; i++) begin
         send_byte(pk[i], i != bad_stop);
         if (i == bad_stop) begin
            send_bit(1'b1);
            return;
         end
      end
   endtask

   typedef struct {
      logic [7:0] b1, b2, b3, b4, crc_xor;
      int         bad_stop;
      int         e_val, e_crc, e_hdr, e_frm;
      logic [1:0] e_btn;
      logic [3:0] e_saf;
      logic [7:0] e_dx, e_dy, e_fid, e_err;
   } vec_t;

   vec_t vecs [8];

   initial begin
      vecs[0] = '{8'h5D, 8'h05, 8'hFB, 8'h07, 8'h00, -1, 1, 0, 0, 0, 2'b01, 4'hD, 8'h05, 8'hFB, 8'h07, 8'd0};
      vecs[1] = '{8'h5D, 8'h05, 8'hFB, 8'h07, 8'h01, -1, 0, 1, 0, 0, 2'b01, 4'hD, 8'h05, 8'hFB, 8'h07, 8'd1};
      vecs[2] = '{8'h9D, 8'h05, 8'hFB, 8'h08, 8'h00, -1, 0, 0, 1, 0, 2'b01, 4'hD, 8'h05, 8'hFB, 8'h07, 8'd2};
      vecs[3] = '{8'h6A, 8'h80, 8'h7F, 8'h09, 8'h00, -1, 1, 0, 0, 0, 2'b10, 4'hA, 8'h80, 8'h7F, 8'h09, 8'd2};
      vecs[4] = '{8'h5D, 8'h11, 8'h22, 8'h0A, 8'h00,  3, 0, 0, 0, 1, 2'b10, 4'hA, 8'h80, 8'h7F, 8'h09, 8'd3};
      vecs[5] = '{8'h4C, 8'hFF, 8'h01, 8'h0B, 8'h00, -1, 1, 0, 0, 0, 2'b00, 4'hC, 8'hFF, 8'h01, 8'h0B, 8'd3};
      vecs[6] = '{8'h1D, 8'h01, 8'h02, 8'h03, 8'h80, -1, 0, 0, 1, 0, 2'b00, 4'hC, 8'hFF, 8'h01, 8'h0B, 8'd4};
      vecs[7] = '{8'h73, 8'h00, 8'h00, 8'h0C, 8'h00, -1, 1, 0, 0, 0, 2'b11, 4'h3, 8'h00, 8'h00, 8'h0C, 8'd4};

      repeat (5) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("reset valid", {31'd0, valid}, 32'd0);
      chk("reset fields", {14'd0, buttons, safety_flags, dx}, 32'd0);
      chk("reset dy/fid", {16'd0, dy, frame_id}, 32'd0);
      chk("reset strobes", {27'd0, crc_err, hdr_err, frame_err, timeout_err, seq_gap}, 32'd0);
      chk("reset counters", {16'd0, err_count, drop_count}, 32'd0);
      idle_bits(2);

      for (int v = 0; v < 8; v++) begin
         snap();
         send_pkt(vecs[v].b1, vecs[v].b2, vecs[v].b3, vecs[v].b4, vecs[v].crc_xor, vecs[v].bad_stop);
         idle_bits(3);
         chk($sformatf("v%0d valid", v), 32'(c_val - s_val), 32'(vecs[v].e_val));
         chk($sformatf("v%0d crc_err", v), 32'(c_crc - s_crc), 32'(vecs[v].e_crc));
         chk($sformatf("v%0d hdr_err", v), 32'(c_hdr - s_hdr), 32'(vecs[v].e_hdr));
         chk($sformatf("v%0d frame_err", v), 32'(c_frm - s_frm), 32'(vecs[v].e_frm));
         chk($sformatf("v%0d timeout_err", v), 32'(c_to - s_to), 32'd0);
         chk($sformatf("v%0d buttons", v), {30'd0, buttons}, {30'd0, vecs[v].e_btn});
         chk($sformatf("v%0d safety", v), {28'd0, safety_flags}, {28'd0, vecs[v].e_saf});
         chk($sformatf("v%0d dx", v), {24'd0, dx}, {24'd0, vecs[v].e_dx});
         chk($sformatf("v%0d dy", v), {24'd0, dy}, {24'd0, vecs[v].e_dy});
         chk($sformatf("v%0d frame_id", v), {24'd0, frame_id}, {24'd0, vecs[v].e_fid});
         chk($sformatf("v%0d err_count", v), {24'd0, err_count}, {24'd0, vecs[v].e_err});
      end

      // three bytes then silence well beyond the 20 bit-time limit
      snap();
      send_byte(8'hAA, 1'b1); send_byte(8'h5D, 1'b1); send_byte(8'h05, 1'b1);
      idle_bits(25);
      chk("timeout strobe", 32'(c_to - s_to), 32'd1);
      chk("timeout err_count", {24'd0, err_count}, 32'd5);
      snap();
      send_byte(8'h12, 1'b1); send_byte(8'h34, 1'b1);
      send_pkt(8'h5D, 8'h01, 8'h02, 8'h0D, 8'h00, -1);
      idle_bits(3);
      chk("post-timeout valid", 32'(c_val - s_val), 32'd1);
      chk("post-timeout no errors", 32'((c_crc - s_crc) + (c_hdr - s_hdr) + (c_frm - s_frm) + (c_to - s_to)), 32'd0);
      chk("post-timeout frame_id", {24'd0, frame_id}, 32'h0D);

      // short low pulse shorter than half a bit must be ignored
      snap();
      @(negedge clk); rx = 1'b0;
      repeat (2) @(negedge clk); rx = 1'b1;
      idle_bits(3);
      send_pkt(8'h5D, 8'h03, 8'h04, 8'h0E, 8'h00, -1);
      idle_bits(3);
      chk("glitch no frame_err", 32'(c_frm - s_frm), 32'd0);
      chk("glitch then valid", 32'(c_val - s_val), 32'd1);
      chk("glitch err_count", {24'd0, err_count}, 32'd5);

      // reset in the middle of a packet and of a byte
      snap();
      send_byte(8'hAA, 1'b1); send_byte(8'h5D, 1'b1);
      send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
      rx = 1'b1; rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("midreset fields", {8'd0, frame_id, dx, err_count}, 32'd0);
      idle_bits(3);
      chk("midreset no strobes", 32'((c_val - s_val) + (c_crc - s_crc) + (c_hdr - s_hdr) + (c_frm - s_frm) + (c_to - s_to)), 32'd0);
      send_pkt(8'h5D, 8'h05, 8'hFB, 8'h20, 8'h00, -1);
      idle_bits(3);
      chk("midreset next valid", 32'(c_val - s_val), 32'd1);
      chk("midreset frame_id", {24'd0, frame_id}, 32'h20);
      chk("midreset dy", {24'd0, dy}, 32'hFB);

      // err_count saturates at 255
      snap();
      for (int i = 0; i < 260; i++) begin
         send_byte(8'h3C, 1'b0);
         send_bit(1'b1);
      end
      idle_bits(2);
      chk("sat frame_err count", 32'(c_frm - s_frm), 32'd260);
      chk("sat err_count", {24'd0, err_count}, 32'd255);

`ifdef CURSOR_RX_SEQ_CHECK_EN
      rst = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      idle_bits(2);
      snap();
      send_pkt(8'h5D, 8'h00, 8'h00, 8'h10, 8'h00, -1);
      send_pkt(8'h5D, 8'h00, 8'h00, 8'h11, 8'h00, -1);
      idle_bits(2);
      chk("seq in-order no gap", 32'(c_seq - s_seq), 32'd0);
      send_pkt(8'h5D, 8'h00, 8'h00, 8'h14, 8'h00, -1);
      idle_bits(2);
      chk("seq gap strobe", 32'(c_seq - s_seq), 32'd1);
      chk("seq drop_count", {24'd0, drop_count}, 32'd2);
      send_pkt(8'h5D, 8'h00, 8'h00, 8'h14, 8'h00, -1);
      idle_bits(2);
      chk("seq repeat gap", 32'(c_seq - s_seq), 32'd2);
      chk("seq drop saturate", {24'd0, drop_count}, 32'd255);
`else
      chk("no seq_gap strobes", 32'(c_seq), 32'd0);
      chk("drop_count tied 0", {24'd0, drop_count}, 32'd0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
